// File: rtl/lesson_ctrl.sv
// Lesson-mode sequencer: picks a song tutor, arms it with a one-cycle START,
// shows its hint LEDs, scores wrong key onsets and watches for song completion
// or player inactivity. Free-play mode lights the LED of the held note.
module lesson_ctrl #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000,
    parameter logic [3:0]  NOTE_NONE   = 4'd0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        GO,
    input  logic [1:0]  MODE_SEL,
    input  logic [3:0]  note,
    input  logic [23:0] song_led,
    input  logic [2:0]  song_done,
    output logic [2:0]  song_start,
    output logic [7:0]  Led,
    output logic [7:0]  mistakes,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FREE,
        S_ARM,
        S_PLAY,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  sel_reg, sel_next;
    logic [31:0] idle_cnt_reg, idle_cnt_next;
    logic [3:0]  prev_note_reg;
    logic [7:0]  mistakes_reg, mistakes_next;
    logic [7:0]  led_reg, led_next;
    logic [2:0]  song_start_reg, song_start_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        timeout_reg, timeout_next;

    logic [7:0]  note_onehot;
    logic [7:0]  hint;
    logic        sel_done;
    logic        onset;
    logic        wrong_key;

    // Codes 1..8 light LED bits 0..7; NOTE_NONE and codes above 8 decode to nothing.
    for (genvar gi = 0; gi < 8; gi++) begin : g_note_dec
        assign note_onehot[gi] = (note == 4'(gi + 1));
    end

    // Hint slice and completion flag of the currently selected tutor.
    always_comb begin
        hint     = 8'd0;
        sel_done = 1'b0;
        case (sel_reg)
            2'd1: begin hint = song_led[7:0];   sel_done = song_done[0]; end
            2'd2: begin hint = song_led[15:8];  sel_done = song_done[1]; end
            2'd3: begin hint = song_led[23:16]; sel_done = song_done[2]; end
            default: ;
        endcase
    end

    // An onset is a press out of silence; sliding between keys does not count.
    // A key outside the hint (including undecodable codes) is a wrong key.
    assign onset     = (note != NOTE_NONE) && (prev_note_reg == NOTE_NONE);
    assign wrong_key = ((note_onehot & hint) == 8'd0);

    // Next-state, selection, scoring and inactivity counter.
    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        idle_cnt_next = idle_cnt_reg;
        mistakes_next = mistakes_reg;
        case (state_reg)
            S_IDLE: begin
                if (MODE_SEL == 2'd0) begin
                    state_next = S_FREE;
                end else if (GO) begin
                    state_next    = S_ARM;
                    sel_next      = MODE_SEL;
                    mistakes_next = 8'd0;
                end
            end
            S_FREE: begin
                if (MODE_SEL != 2'd0) state_next = S_IDLE;
            end
            S_ARM: begin
                idle_cnt_next = 32'd0;
                state_next    = S_PLAY;
            end
            S_PLAY: begin
                // Scoring happens first so an onset coinciding with completion
                // or abort still lands in the score; a restart wipes it anyway.
                idle_cnt_next = onset ? 32'd0 : idle_cnt_reg + 32'd1;
                if (onset && wrong_key && (mistakes_reg != 8'hFF))
                    mistakes_next = mistakes_reg + 8'd1;
                if (MODE_SEL != sel_reg) begin
                    state_next = S_IDLE;
                end else if (GO) begin
                    state_next    = S_ARM;
                    mistakes_next = 8'd0;
                end else if (sel_done) begin
                    state_next = S_DONE;
                end else if (idle_cnt_reg == TIMEOUT_CYC - 32'd1) begin
                    state_next = S_TIMEOUT;
                end
            end
            S_DONE, S_TIMEOUT: begin
                if (GO || (MODE_SEL != sel_reg)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register alongside it.
    always_comb begin
        led_next        = 8'd0;
        song_start_next = 3'd0;
        case (state_next)
            S_FREE:    led_next = note_onehot;
            S_PLAY:    led_next = hint;
            S_DONE:    led_next = mistakes_next;
            S_TIMEOUT: led_next = 8'hFF;
            S_ARM: begin
                case (sel_next)
                    2'd1:    song_start_next = 3'b001;
                    2'd2:    song_start_next = 3'b010;
                    2'd3:    song_start_next = 3'b100;
                    default: song_start_next = 3'b000;
                endcase
            end
            default: ;
        endcase
        busy_next    = (state_next == S_ARM) || (state_next == S_PLAY);
        done_next    = (state_next == S_DONE) && (state_reg != S_DONE);
        timeout_next = (state_next == S_TIMEOUT);
    end

    // State and registered outputs; RESET clears everything at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg      <= S_IDLE;
            sel_reg        <= 2'd0;
            idle_cnt_reg   <= 32'd0;
            prev_note_reg  <= NOTE_NONE;
            mistakes_reg   <= 8'd0;
            led_reg        <= 8'd0;
            song_start_reg <= 3'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            idle_cnt_reg   <= idle_cnt_next;
            prev_note_reg  <= note;
            mistakes_reg   <= mistakes_next;
            led_reg        <= led_next;
            song_start_reg <= song_start_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign song_start = song_start_reg;
    assign Led        = led_reg;
    assign mistakes   = mistakes_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign timeout    = timeout_reg;

endmodule
